// File: rtl/slow_mem_pkg.sv
// slow_mem_pkg: shared types and widths for the slow line-memory responder
package slow_mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_e;
  localparam int LINE_W = 128;
  localparam int MEM_ADDR_W = 28;
endpackage

// File: rtl/slow_mem_responder_if.sv
// slow_mem_responder_if: cache-to-memory line request/response bundle
interface slow_mem_responder_if;
  import slow_mem_pkg::*;
  logic mem_read;
  logic mem_write;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic mem_ready;
  modport master(output mem_read, mem_write, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave(input mem_read, mem_write, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/slow_mem_line_ram.sv
// slow_mem_line_ram: line array with protocol/backdoor write, registered and async reads
module slow_mem_line_ram
  import slow_mem_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [LINE_W-1:0]    wdata,
  input  logic                 dbg_we,
  input  logic [ADDR_BITS-1:0] dbg_addr,
  input  logic [LINE_W-1:0]    dbg_wdata,
  output logic [LINE_W-1:0]    rdata,
  output logic [LINE_W-1:0]    dbg_rdata
);
  logic [LINE_W-1:0] mem [2**ADDR_BITS];
  // protocol write is issued last so it overrides a same-index backdoor write
  always_ff @(posedge clk) begin
    if (dbg_we) mem[dbg_addr] <= dbg_wdata;
    if (we) mem[addr] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[addr];
  end
  assign dbg_rdata = mem[dbg_addr];
endmodule

// File: rtl/slow_mem_responder.sv
// slow_mem_responder: fixed-latency line memory completing one request at a time
module slow_mem_responder
  import slow_mem_pkg::*;
#(
  parameter int LATENCY = 8,
  parameter int ADDR_BITS = 10,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 proc_reset,
  slow_mem_responder_if.slave  bus,
  input  logic                 dbg_we,
  input  logic [ADDR_BITS-1:0] dbg_addr,
  input  logic [LINE_W-1:0]    dbg_wdata,
  output logic [LINE_W-1:0]    dbg_rdata,
  output logic [CNT_W-1:0]     txn_cnt,
  output logic                 err_proto
);
  localparam int CW = $clog2(LATENCY + 1);
  state_e state, state_nx;
  logic [CW-1:0] cnt;
  logic rd_q, wr_q, req, done, bad;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q, rdata;
  assign req = bus.mem_read | bus.mem_write;
  assign done = state == BUSY && cnt == '0;
  // request must stay identical from acceptance through the ready cycle
  assign bad = (state == BUSY || state == RESP) &&
               ({bus.mem_read, bus.mem_write} != {rd_q, wr_q} || bus.mem_addr != addr_q);
  always_comb begin
    state_nx = state == IDLE ? (req ? BUSY : IDLE) :
               state == BUSY ? (cnt == '0 ? RESP : BUSY) :
               state == RESP ? GAP : IDLE;
  end
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state <= IDLE;
      cnt <= '0;
      txn_cnt <= '0;
      err_proto <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        {rd_q, wr_q} <= {bus.mem_read, bus.mem_write};
        addr_q <= bus.mem_addr;
        wdata_q <= bus.mem_wdata;
        cnt <= CW'(LATENCY - 1);
      end else if (state == BUSY && cnt != '0) cnt <= cnt - 1'b1;
      if (state == RESP) txn_cnt <= txn_cnt + 1'b1;
      err_proto <= err_proto | bad | (state == IDLE && bus.mem_read && bus.mem_write);
    end
  end
  slow_mem_line_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clk(clk),
    .rst(proc_reset),
    .we(done && wr_q && !proc_reset),
    .re(done && !wr_q),
    .addr(addr_q[ADDR_BITS-1:0]),
    .wdata(wdata_q),
    .dbg_we(dbg_we),
    .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata),
    .rdata(rdata),
    .dbg_rdata(dbg_rdata)
  );
  assign bus.mem_rdata = rdata;
  assign bus.mem_ready = state == RESP;
endmodule

// File: tb/tb_slow_mem_responder.sv
// tb_slow_mem_responder: randomized scoreboard bench against a transaction-level memory model
module tb_slow_mem_responder;
  localparam int LAT = 8;
  typedef struct {
    int          cyc;
    logic [127:0] rdata;
    logic [15:0]  cnt;
    logic         err;
  } exp_t;

  logic clk = 0, proc_reset = 1;
  logic dbg_we = 0, dbg1_we = 0;
  logic [9:0] dbg_addr = 0, dbg1_addr = 0;
  logic [127:0] dbg_wdata = 0, dbg1_wdata = 0, dbg_rdata, dbg1_rdata;
  logic [15:0] txn_cnt, txn_cnt1;
  logic err_proto, err1;
  int cyc = 0, checks = 0, errors = 0;

  logic [127:0] ref_mem [1024];
  logic [127:0] ref_rdata = 0;
  logic [15:0] ref_cnt = 0;
  logic ref_err = 0;
  int last_ready = -100;
  exp_t q[$];

  slow_mem_responder_if bus ();
  slow_mem_responder_if bus1 ();

  slow_mem_responder #(.LATENCY(LAT), .ADDR_BITS(10), .CNT_W(16)) dut (
    .clk(clk), .proc_reset(proc_reset), .bus(bus.slave),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata),
    .txn_cnt(txn_cnt), .err_proto(err_proto)
  );
  slow_mem_responder #(.LATENCY(1), .ADDR_BITS(10), .CNT_W(16)) dut1 (
    .clk(clk), .proc_reset(proc_reset), .bus(bus1.slave),
    .dbg_we(dbg1_we), .dbg_addr(dbg1_addr), .dbg_wdata(dbg1_wdata), .dbg_rdata(dbg1_rdata),
    .txn_cnt(txn_cnt1), .err_proto(err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endfunction

  // monitor: every ready pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.mem_ready === 1'b1) begin
      if (q.size() == 0) chk("unexpected_ready", {127'b0, bus.mem_ready}, 128'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("ready_cycle", 128'(cyc), 128'(e.cyc));
        chk("mem_rdata", bus.mem_rdata, e.rdata);
        chk("txn_cnt", {112'b0, txn_cnt}, {112'b0, e.cnt});
        chk("err_proto", {127'b0, err_proto}, {127'b0, e.err});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_write(input logic [9:0] i, input logic [127:0] d);
    dbg_we = 1; dbg_addr = i; dbg_wdata = d;
    step();
    dbg_we = 0;
    ref_mem[i] = d;
  endtask

  task automatic model_reset();
    ref_cnt = 0; ref_err = 0; ref_rdata = 0; last_ready = -100;
  endtask

  task automatic txn(input logic rd, input logic wr, input logic [27:0] a,
                     input logic [127:0] d, input int bad_at);
    int acc, n;
    exp_t e;
    logic [9:0] i;
    i = a[9:0];
    acc = (cyc > last_ready + 2) ? cyc : last_ready + 2;
    bus.mem_read = rd; bus.mem_write = wr; bus.mem_addr = a; bus.mem_wdata = d;
    if ((rd && wr) || bad_at > 0) ref_err = 1;
    if (wr) ref_mem[i] = d;
    else ref_rdata = ref_mem[i];
    e.cyc = acc + LAT + 1; e.rdata = ref_rdata; e.cnt = ref_cnt; e.err = ref_err;
    q.push_back(e);
    ref_cnt++;
    last_ready = e.cyc;
    if (bad_at > 0) begin
      while (cyc < acc + bad_at) step();
      bus.mem_addr = a ^ 28'h155;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.mem_ready !== 1'b1 && n < 400);
    chk("ready_seen", {127'b0, bus.mem_ready}, 128'd1);
    step();
    bus.mem_read = 0; bus.mem_write = 0;
    if (wr) begin
      dbg_addr = i;
      #1 chk("dbg_after_write", dbg_rdata, ref_mem[i]);
    end
  endtask

  function automatic logic [27:0] rand_addr();
    return {18'($urandom), 6'd0, 4'($urandom)};
  endfunction

  initial begin
    int acc;
    logic [127:0] p, d;
    logic rd;
    bus.mem_read = 0; bus.mem_write = 0; bus.mem_addr = 0; bus.mem_wdata = 0;
    bus1.mem_read = 0; bus1.mem_write = 0; bus1.mem_addr = 0; bus1.mem_wdata = 0;
    repeat (3) @(posedge clk);
    #1 proc_reset = 0;
    chk("rst_ready", {127'b0, bus.mem_ready}, 128'd0);
    chk("rst_rdata", bus.mem_rdata, 128'd0);
    chk("rst_txn_cnt", {112'b0, txn_cnt}, 128'd0);
    chk("rst_err", {127'b0, err_proto}, 128'd0);
    for (int i = 0; i < 16; i++) dbg_write(10'(i), {4{$urandom}});
    dbg_write(10'h3FF, 128'h0);
    dbg_write(10'h005, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
    txn(1, 0, 28'h000_0005, 128'h0, 0);
    txn(0, 1, 28'h000_03FF, {4{32'hDEADBEEF}}, 0);
    txn(1, 0, 28'h000_03FF, 128'h0, 0);
    txn(0, 1, 28'h000_0403, {4{$urandom}}, 0);
    txn(1, 0, 28'h000_0003, 128'h0, 0);
    repeat (30) begin
      rd = 1'($urandom);
      txn(rd, !rd, rand_addr(), {4{$urandom}}, 0);
      repeat ($urandom_range(0, 2)) step();
    end
    txn(1, 1, rand_addr(), {4{$urandom}}, 0);
    txn(1, 0, rand_addr(), 128'h0, 0);
    proc_reset = 1; step(); proc_reset = 0; model_reset();
    txn(0, 1, 28'h000_0007, {4{$urandom}}, 3);
    txn(1, 0, 28'h000_0007, 128'h0, 0);
    acc = (cyc > last_ready + 2) ? cyc : last_ready + 2;
    bus.mem_write = 1; bus.mem_addr = 28'h000_0009; bus.mem_wdata = {4{$urandom}};
    while (cyc < acc + 4) step();
    proc_reset = 1; bus.mem_write = 0;
    step();
    proc_reset = 0;
    dbg_addr = 10'h009;
    #1 chk("rst_mid_line", dbg_rdata, ref_mem[9]);
    chk("rst_mid_cnt", {112'b0, txn_cnt}, 128'd0);
    chk("rst_mid_err", {127'b0, err_proto}, 128'd0);
    chk("rst_mid_rdata", bus.mem_rdata, 128'd0);
    model_reset();
    repeat (12) step();
    txn(1, 0, 28'h000_0009, 128'h0, 0);
    txn(0, 1, rand_addr(), {4{$urandom}}, 0);
    // LATENCY=1 responder: commit vs same-edge backdoor write to line 7
    p = {4{$urandom}}; d = ~p;
    bus1.mem_write = 1; bus1.mem_addr = 28'h000_0007; bus1.mem_wdata = p;
    @(negedge clk) chk("l1_ready_acc", {127'b0, bus1.mem_ready}, 128'd0);
    step();
    dbg1_we = 1; dbg1_addr = 10'h007; dbg1_wdata = d;
    @(negedge clk) chk("l1_ready_busy", {127'b0, bus1.mem_ready}, 128'd0);
    step();
    dbg1_we = 0;
    @(negedge clk) begin
      chk("l1_ready_resp", {127'b0, bus1.mem_ready}, 128'd1);
      chk("l1_collision", dbg1_rdata, p);
    end
    step();
    bus1.mem_write = 0;
    bus1.mem_read = 1;
    @(negedge clk) begin
      chk("l1_ready_gap", {127'b0, bus1.mem_ready}, 128'd0);
      chk("l1_txn_cnt", {112'b0, txn_cnt1}, 128'd1);
    end
    repeat (3) step();
    @(negedge clk) begin
      chk("l1_read_ready", {127'b0, bus1.mem_ready}, 128'd1);
      chk("l1_read_data", bus1.mem_rdata, p);
      chk("l1_err", {127'b0, err1}, 128'd0);
    end
    step();
    bus1.mem_read = 0;
    repeat (4) step();
    chk("queue_drained", 128'(q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog_timeout got running expected finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/slow_mem_responder.md
Name: slow_mem_responder

Overview:
- Memory-side responder for the cache block interface (mem_read/mem_write/mem_addr[31:4]/128-bit data/mem_ready), one instance per cache (D and I).
- Models a slow line-granular memory: accepts one 128-bit line request at a time, waits a programmable latency, then completes it with a single-cycle mem_ready pulse.
- Used as the bench-side and FPGA-side memory behind the cache instances; also exposes a backdoor port for preload/checking.

Parameters:
- LATENCY, 8, cycles spent in BUSY before the response; legal range 1..255.
- ADDR_BITS, 10, line-index width; depth is 2^ADDR_BITS lines.
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- proc_reset  in  1  synchronous, active-high reset.
- mem_read  in  1  line read request, held by the cache until mem_ready.
- mem_write  in  1  line write request, held until mem_ready.
- mem_addr  in  28  line address [31:4].
- mem_wdata  in  128  write line data.
- mem_rdata  out  128  read line data, valid in the mem_ready cycle.
- mem_ready  out  1  one-cycle completion pulse.
- dbg_we  in  1  backdoor line write.
- dbg_addr  in  ADDR_BITS  backdoor line index.
- dbg_wdata  in  128  backdoor write data.
- dbg_rdata  out  128  combinational array read at dbg_addr.
- txn_cnt  out  CNT_W  completed transactions, wraps.
- err_proto  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (proc_reset=1 at an edge): state=IDLE, counter=0, mem_ready=0, mem_rdata=0, txn_cnt=0, err_proto=0. Any in-flight transaction is discarded and its write is not committed. Array contents are not cleared.
- Index = mem_addr[ADDR_BITS+3:4]. Upper address bits are ignored, so out-of-range addresses alias.
- FSM states: IDLE, BUSY, RESP, GAP.
- IDLE: if mem_read|mem_write is sampled in cycle C, latch index, op and wdata; load counter=LATENCY-1; go to BUSY.
- IDLE, both requests high: treat as a write and set err_proto.
- BUSY (cycles C+1..C+LATENCY):
  - Counter decrements each edge.
  - On the edge where counter==0, go to RESP.
  - On that same edge: for a write, commit the latched wdata to the array; for a read, register array[index] into mem_rdata.
- RESP (cycle C+LATENCY+1): mem_ready=1 for exactly this cycle; txn_cnt increments on the leaving edge; go to GAP.
- GAP (cycle C+LATENCY+2): requests are ignored; go to IDLE. The earliest next acceptance is cycle C+LATENCY+3. GAP prevents re-triggering on a request the cache has not yet dropped.
- Back-to-back write-back followed by allocate-read is served as two transactions, each with full latency.
- mem_rdata holds its value until the next read response; write transactions do not change it.
- Stability check: err_proto is set if, during BUSY or RESP, the request drops, the op changes, or mem_addr differs from the latched value. The transaction still completes using the latched values.
- err_proto clears only on reset.
- Backdoor write: dbg_we writes dbg_wdata at dbg_addr on the edge, in any state.
  - If it targets the same index on the same edge as a protocol commit, the protocol commit wins.
  - A backdoor write to the latched index before the read-sampling edge is visible in the read data.
- dbg_rdata is combinational and reflects commits from the next cycle onward.
- Counter width is $clog2(LATENCY+1). LATENCY=1 gives exactly one BUSY cycle.

Decomposition:
- Package slow_mem_pkg:
  - state enum {IDLE, BUSY, RESP, GAP};
  - LINE_W=128;
  - MEM_ADDR_W=28.
- One sub-module, slow_mem_line_ram:
  - 2^ADDR_BITS x 128 array;
  - one synchronous write port with priority given to the protocol commit;
  - one registered read port for the protocol side;
  - one asynchronous read port for the debug side.
- The FSM, counter, latches and error logic stay in slow_mem_responder.

Test Plan:
- Read after preload: dbg write line 0x005 = 0x0123_4567_89AB_CDEF_0011_2233_4455_6677; read mem_addr=0x000_0005 in cycle 10 with LATENCY=8 -> mem_ready high only in cycle 19, mem_rdata equals the pattern, txn_cnt=1.
- Write then read: write 0xDEADBEEF replicated to line 0x3FF, then read it back -> dbg_rdata at 0x3FF shows the data from the cycle after the write RESP; the read returns the same data; the next acceptance is no earlier than RESP+2.
- Aliasing: with ADDR_BITS=10, write line address 0x000_0403 -> the data lands at index 0x003; a read of 0x000_0003 returns it.
- Protocol errors:
  - mem_read and mem_write both high at acceptance -> handled as a write, err_proto=1;
  - separately, mem_addr changed mid-BUSY -> err_proto=1, completion uses the original address.
- Reset mid-BUSY: assert proc_reset during the 4th BUSY cycle of a write -> mem_ready never pulses, the array line is unchanged, outputs return to 0, and a new request after reset completes normally.
- Collision and minimum latency: LATENCY=1 with dbg_we to the same index on the commit edge -> the array holds the protocol data; mem_ready asserts two cycles after the acceptance cycle.
